// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO store snooper feeding a FIFO drained as 8N1 UART frames; define MMIO_UART_PARITY_EN for an even-parity bit
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h0000_0064,
    parameter int          DEPTH        = 8,
    parameter int          CLKS_PER_BIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_enab,
    input  logic [31:0]                  data_addr,
    input  logic [31:0]                  write_data,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         fifo_full,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
`ifdef MMIO_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            tx_q, tx_d;
    logic [7:0]      mem_q [DEPTH];
    logic            tick, non_empty, pop, push_req, push;
    logic            unused_ok;
`ifdef MMIO_UART_PARITY_EN
    logic            par_q, par_d;
`endif
    assign unused_ok  = ^write_data[31:8];
    assign tick       = timer_q == TW'(CLKS_PER_BIT - 1);
    assign non_empty  = count_q != '0;
    assign pop        = non_empty && (state_q == IDLE || (state_q == STOP && tick));
    assign push_req   = write_enab && data_addr == TX_ADDR;
    assign push       = push_req && (!fifo_full || pop);
    assign tx         = tx_q;
    assign busy       = state_q != IDLE;
    assign fifo_count = count_q;
    assign fifo_full  = count_q == CW'(DEPTH);
    assign overflow   = overflow_q;

    // FIFO bookkeeping: pointers wrap naturally since DEPTH is a power of two; a refused push is remembered forever
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q | (push_req & ~push);
`ifdef MMIO_UART_PARITY_EN
        par_d      = pop ? ^mem_q[rd_ptr_q] : par_q;
`endif
    end

    // FIFO storage needs no reset: emptiness is tracked by the pointers and count alone
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= write_data[7:0];
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Next state plus bit timer, bit index and shifter; a pop reloads the shifter for a fresh frame
    always_comb begin
        state_d = state_q;
        timer_d = (state_q == IDLE || tick) ? '0 : timer_q + TW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE:  if (non_empty) state_d = START;
            START: if (tick) state_d = DATA;
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
`ifdef MMIO_UART_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP:    if (tick) state_d = non_empty ? START : IDLE;
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
        end
    end

    // Output decode from the next state so the registered tx lines up with the state it belongs to
    always_comb begin
        tx_d = 1'b1;
        if (state_d == START) tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
        else if (state_d == PARITY) tx_d = par_q;
`endif
    end

    // Datapath registers; reset abandons any frame and empties the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
`ifdef MMIO_UART_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus with an expected-frame queue checked by a UART receiver monitor
module tb_mmio_uart_tx;
    localparam int CPB = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_enab = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] write_data = '0;
    logic        tx, busy, fifo_full, overflow;
    logic [3:0]  fifo_count;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];

    mmio_uart_tx dut (
        .clk(clk), .reset(reset), .write_enab(write_enab), .data_addr(data_addr),
        .write_data(write_data), .tx(tx), .busy(busy), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        write_enab = 1'b1;
        data_addr  = a;
        write_data = d;
        @(negedge clk);
        write_enab = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || fifo_count != 0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) chk("idle_timeout", 1, 0);
        repeat (4) @(negedge clk);
    endtask

    // Receiver: finds the start bit, samples each bit mid-cell, compares against the queue head
    initial begin
        logic [10:0] bits;
        logic        abort;
        logic [7:0]  e;
        bits = '0;
        @(negedge clk);
        forever begin
            while (!(reset && !tx)) @(negedge clk);
            abort = 1'b0;
            for (int b = 0; b < NB; b++)
                for (int c = 0; c < CPB; c++) begin
                    if (c == CPB / 2) bits[b] = tx;
                    if (!reset) abort = 1'b1;
                    @(negedge clk);
                end
            if (!abort) begin
                if (exp_q.size() == 0) chk("unexpected_frame", {24'h0, bits[8:1]}, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("frame_data", {24'h0, bits[8:1]}, {24'h0, e});
                    chk("start_bit", {31'h0, bits[0]}, 0);
                    chk("stop_bit", {31'h0, bits[NB-1]}, 1);
`ifdef MMIO_UART_PARITY_EN
                    chk("parity_bit", {31'h0, bits[9]}, {31'h0, ^e});
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  n;
        logic saw;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'h0, tx}, 1);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_count", {28'h0, fifo_count}, 0);
        chk("rst_full", {31'h0, fifo_full}, 0);
        chk("rst_overflow", {31'h0, overflow}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tx", {31'h0, tx}, 1);
        chk("idle_busy", {31'h0, busy}, 0);
        chk("idle_count", {28'h0, fifo_count}, 0);

        // single character and its exact timing
        exp_q.push_back(8'h07);
        store(32'h64, 32'h0000_0007);
        chk("single_count1", {28'h0, fifo_count}, 1);
        chk("single_tx_before", {31'h0, tx}, 1);
        @(negedge clk);
        chk("single_tx_fall", {31'h0, tx}, 0);
        chk("single_count0", {28'h0, fifo_count}, 0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("single_busy_len", n, NB * CPB);
        wait_idle();

        // address filter and high-byte masking
        store(32'h60, 32'hFFFF_FF41);
        chk("filter_other_addr", {28'h0, fifo_count}, 0);
        exp_q.push_back(8'h41);
        store(32'h64, 32'h0000_0041);
        chk("filter_count", {28'h0, fifo_count}, 1);
        wait_idle();

        // burst: back-to-back frames with no idle gap
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h0F);
        store(32'h64, 32'h55);
        chk("burst_c1", {28'h0, fifo_count}, 1);
        store(32'h64, 32'hAA);
        chk("burst_c2", {28'h0, fifo_count}, 1);
        store(32'h64, 32'h0F);
        chk("burst_peak", {28'h0, fifo_count}, 2);
        n = 1;
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("burst_busy_len", n, 3 * NB * CPB);
        wait_idle();

        // overflow: nine of ten accepted, tenth dropped
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 10; i++) begin
            store(32'h64, i);
            if (i == 8) chk("ovf_before", {31'h0, overflow}, 0);
        end
        chk("ovf_set", {31'h0, overflow}, 1);
        chk("ovf_count", {28'h0, fifo_count}, 8);
        chk("ovf_full", {31'h0, fifo_full}, 1);
        // push on the edge where the first frame's stop ends: full with simultaneous pop
        repeat (NB * CPB - 9) @(negedge clk);
        chk("full_pre", {28'h0, fifo_count}, 8);
        exp_q.push_back(8'h0A);
        store(32'h64, 32'h0A);
        chk("full_pop_count", {28'h0, fifo_count}, 8);
        chk("ovf_sticky", {31'h0, overflow}, 1);
        wait_idle();
        chk("ovf_sticky_idle", {31'h0, overflow}, 1);

        // reset during data bit 3 with two entries queued
        store(32'h64, 32'h33);
        store(32'h64, 32'h44);
        store(32'h64, 32'h55);
        chk("mid_queued", {28'h0, fifo_count}, 2);
        repeat (16) @(negedge clk);
        chk("mid_bit3", {31'h0, tx}, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_tx", {31'h0, tx}, 1);
        chk("mid_rst_count", {28'h0, fifo_count}, 0);
        chk("mid_rst_busy", {31'h0, busy}, 0);
        chk("mid_rst_ovf", {31'h0, overflow}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (busy || !tx) saw = 1'b1;
        end
        chk("mid_no_frame", {31'h0, saw}, 0);
        chk("mid_count_after", {28'h0, fifo_count}, 0);
        chk("all_frames_seen", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
